ex_muldiv_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 22 ++
 rtl/muldiv_iter_step.sv | 56 +++++
 rtl/ex_muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32M definitions for the EX-stage multiply/divide unit:
// funct3 encodings, iteration FSM states and the default word width.
package rv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One CALC cycle of the iterative datapath: UNROLL chained single-bit
// shift-add (multiply) or restoring-subtract (divide) stages.
module muldiv_iter_step
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int UNROLL = 1
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opb,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);

   for (genvar g = 0; g < UNROLL; g++) begin : g_bit
      logic [XLEN-1:0] hi_in_s;
      logic [XLEN-1:0] lo_in_s;
      logic [XLEN-1:0] hi_out_s;
      logic [XLEN-1:0] lo_out_s;
      logic [XLEN:0]   add_s;
      logic [XLEN:0]   shl_s;
      logic            ge_s;
      logic [XLEN-1:0] diff_s;

      if (g == 0) begin : g_head
         assign hi_in_s = hi;
         assign lo_in_s = lo;
      end else begin : g_link
         assign hi_in_s = g_bit[g-1].hi_out_s;
         assign lo_in_s = g_bit[g-1].lo_out_s;
      end

      // hi:lo is {partial product, multiplier} for multiply, {remainder, dividend} for divide
      assign add_s  = {1'b0, hi_in_s} + (lo_in_s[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      assign shl_s  = {hi_in_s, lo_in_s[XLEN-1]};
      assign ge_s   = ({1'b0, opb} <= shl_s);
      assign diff_s = shl_s[XLEN-1:0] - opb;

      // Select the multiply or divide update for this bit
      always_comb begin
         if (is_div) begin
            hi_out_s = ge_s ? diff_s : shl_s[XLEN-1:0];
            lo_out_s = {lo_in_s[XLEN-2:0], ge_s};
         end else begin
            hi_out_s = add_s[XLEN:1];
            lo_out_s = {add_s[0], lo_in_s[XLEN-1:1]};
         end
      end
   end

   assign hi_next = g_bit[UNROLL-1].hi_out_s;
   assign lo_next = g_bit[UNROLL-1].lo_out_s;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU: captures an
// M-op, stalls the pipeline while iterating, then presents result/rd for one cycle.
module ex_muldiv_unit
   import rv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam int ITER = XLEN / UNROLL;
   localparam int CW   = $clog2(ITER);
   localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_r;
   state_t          state_n_s;
   logic [2:0]      op_r;
   logic [4:0]      rd_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] hi_r;
   logic [XLEN-1:0] lo_r;
   logic            neg_q_r;
   logic            neg_r_r;
   logic [CW-1:0]   cnt_r;
   logic [XLEN-1:0] result_r;
   logic [4:0]      rd_out_r;
   logic            done_r;

   logic            accept_s;
   logic            last_s;
   logic            a_signed_s;
   logic            b_signed_s;
   logic            a_neg_s;
   logic            b_neg_s;
   logic [XLEN-1:0] a_mag_s;
   logic [XLEN-1:0] b_mag_s;
   logic            div_zero_s;
   logic            div_ovf_s;
   logic            special_s;
   logic [XLEN-1:0] special_res_s;
   logic [XLEN-1:0] step_hi_s;
   logic [XLEN-1:0] step_lo_s;
   logic [2*XLEN-1:0] prod_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0] quo_fix_s;
   logic [XLEN-1:0] rem_fix_s;
   logic [XLEN-1:0] final_res_s;

   assign accept_s = start_i & ~flush_i;
   assign last_s   = (cnt_r == CNT_LAST);
   assign stall_o  = ((state_r == ST_IDLE) & accept_s) | (state_r == ST_CALC);
   assign done_o   = done_r & ~flush_i;
   assign result_o = result_r;
   assign rd_o     = rd_out_r;

   // Operand signedness, magnitudes and RISC-V divide special cases
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (op_i)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         OP_MULHSU: a_signed_s = 1'b1;
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
      a_neg_s = a_signed_s & rs1_i[XLEN-1];
      b_neg_s = b_signed_s & rs2_i[XLEN-1];
      if (a_neg_s) a_mag_s = -rs1_i;
      else         a_mag_s = rs1_i;
      if (b_neg_s) b_mag_s = -rs2_i;
      else         b_mag_s = rs2_i;
      div_zero_s = op_i[2] & (rs2_i == {XLEN{1'b0}});
      div_ovf_s  = op_i[2] & ~op_i[0] & (rs1_i == MIN_NEG) & (rs2_i == {XLEN{1'b1}});
      special_s  = div_zero_s | div_ovf_s;
      // op_i[1] separates REM/REMU from DIV/DIVU
      if (div_zero_s) begin
         special_res_s = op_i[1] ? rs1_i : {XLEN{1'b1}};
      end else if (div_ovf_s) begin
         special_res_s = op_i[1] ? {XLEN{1'b0}} : MIN_NEG;
      end else begin
         special_res_s = {XLEN{1'b0}};
      end
   end

   muldiv_iter_step #(
      .XLEN   (XLEN),
      .UNROLL (UNROLL)
   ) u_step (
      .is_div  (op_r[2]),
      .hi      (hi_r),
      .lo      (lo_r),
      .opb     (b_r),
      .hi_next (step_hi_s),
      .lo_next (step_lo_s)
   );

   // Sign correction and result selection on the final CALC cycle
   always_comb begin
      prod_s = {step_hi_s, step_lo_s};
      if (neg_q_r) begin
         prod_fix_s = -prod_s;
         quo_fix_s  = -step_lo_s;
      end else begin
         prod_fix_s = prod_s;
         quo_fix_s  = step_lo_s;
      end
      if (neg_r_r) rem_fix_s = -step_hi_s;
      else         rem_fix_s = step_hi_s;
      case (op_r)
         OP_MUL:                        final_res_s = prod_fix_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  final_res_s = prod_fix_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               final_res_s = quo_fix_s;
         OP_REM, OP_REMU:               final_res_s = rem_fix_s;
         default:                       final_res_s = {XLEN{1'b0}};
      endcase
   end

   // Next-state logic; start_i is ignored in DONE since the stalled op still drives it
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_n_s = special_s ? ST_DONE : ST_CALC;
            else          state_n_s = ST_IDLE;
         end
         ST_CALC: begin
            if (flush_i)     state_n_s = ST_IDLE;
            else if (last_s) state_n_s = ST_DONE;
            else             state_n_s = ST_CALC;
         end
         ST_DONE: state_n_s = ST_IDLE;
         default: state_n_s = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_n_s;
   end

   // Operand capture and iteration accumulators
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= 3'd0;
         rd_r    <= 5'd0;
         b_r     <= {XLEN{1'b0}};
         hi_r    <= {XLEN{1'b0}};
         lo_r    <= {XLEN{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else if ((state_r == ST_IDLE) && accept_s) begin
         op_r    <= op_i;
         rd_r    <= rd_i;
         b_r     <= b_mag_s;
         hi_r    <= {XLEN{1'b0}};
         lo_r    <= a_mag_s;
         neg_q_r <= a_neg_s ^ b_neg_s;
         neg_r_r <= a_neg_s;
         cnt_r   <= {CW{1'b0}};
      end else if ((state_r == ST_CALC) && !flush_i) begin
         hi_r    <= step_hi_s;
         lo_r    <= step_lo_s;
         cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Output registers: loaded on entry to DONE, held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_r <= {XLEN{1'b0}};
         rd_out_r <= 5'd0;
         done_r   <= 1'b0;
      end else begin
         done_r <= (state_n_s == ST_DONE);
         if ((state_r == ST_IDLE) && accept_s && special_s) begin
            result_r <= special_res_s;
            rd_out_r <= rd_i;
         end else if ((state_r == ST_CALC) && !flush_i && last_s) begin
            result_r <= final_res_s;
            rd_out_r <= rd_r;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench: two units (UNROLL=1 and UNROLL=4) driven with directed and
// random M-ops, checked against an arithmetic reference model.
module tb_ex_muldiv_unit;
   import rv_pkg::*;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_s   [2];
   logic        start_s [2];
   logic [2:0]  op_s    [2];
   logic [31:0] rs1_s   [2];
   logic [31:0] rs2_s   [2];
   logic [4:0]  rd_s    [2];
   logic        flush_s [2];
   logic        stall_s [2];
   logic        done_s  [2];
   logic [31:0] res_s   [2];
   logic [4:0]  rdo_s   [2];

   int   n_checks = 0;
   int   n_fails  = 0;
   int   iters [2] = '{32, 8};
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
      .clk(clk), .rst(rst_s[0]), .start_i(start_s[0]), .op_i(op_s[0]),
      .rs1_i(rs1_s[0]), .rs2_i(rs2_s[0]), .rd_i(rd_s[0]), .flush_i(flush_s[0]),
      .stall_o(stall_s[0]), .done_o(done_s[0]), .result_o(res_s[0]), .rd_o(rdo_s[0])
   );

   ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
      .clk(clk), .rst(rst_s[1]), .start_i(start_s[1]), .op_i(op_s[1]),
      .rs1_i(rs1_s[1]), .rs2_i(rs2_s[1]), .rd_i(rd_s[1]), .flush_i(flush_s[1]),
      .stall_o(stall_s[1]), .done_o(done_s[1]), .result_o(res_s[1]), .rd_o(rdo_s[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         OP_MUL:    begin p = ua * ub; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return $signed(a) / $signed(b);
         end
         OP_DIVU: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            return a / b;
         end
         OP_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h00000000;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   task automatic mon_one(input int d, input logic [31:0] r, input logic [4:0] rdv);
      exp_t e;
      if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
         n_checks++;
         n_fails++;
         $display("FAIL unexpected_done dut%0d: result 0x%08h with no op pending", d, r);
      end else begin
         if (d == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         check($sformatf("result dut%0d", d), r, e.result);
         check($sformatf("rd dut%0d", d), {27'd0, rdv}, {27'd0, e.rd});
      end
   endtask

   // Monitor: compare every presented result against the scoreboard
   always @(negedge clk) begin
      #2;
      if (done_s[0]) mon_one(0, res_s[0], rdo_s[0]);
      if (done_s[1]) mon_one(1, res_s[1], rdo_s[1]);
   end

   // kill_kind: 0 none, 1 flush at CALC cycle kill_at, 2 reset at CALC cycle kill_at
   task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int kill_kind, input int kill_at);
      int   n;
      int   exp_n;
      bit   fin;
      exp_t e;
      exp_n = (op[2] && (b == 32'h0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
              ? 1 : iters[d] + 1;
      @(negedge clk);
      start_s[d] = 1'b1;
      op_s[d]    = op;
      rs1_s[d]   = a;
      rs2_s[d]   = b;
      rd_s[d]    = rd;
      if (kill_kind == 0) begin
         e.result = ref_model(op, a, b);
         e.rd     = rd;
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      n   = 0;
      fin = 1'b0;
      while (!fin) begin
         #1;
         if (!stall_s[d]) begin
            fin = 1'b1;
         end else begin
            n++;
            if (kill_kind != 0 && n == kill_at + 1) begin
               start_s[d] = 1'b0;
               if (kill_kind == 1) begin
                  flush_s[d] = 1'b1;
                  #1;
                  check($sformatf("flush_cycle_done dut%0d", d), {31'd0, done_s[d]}, 32'd0);
                  @(negedge clk);
                  flush_s[d] = 1'b0;
                  #1;
                  check($sformatf("post_flush_stall dut%0d", d), {31'd0, stall_s[d]}, 32'd0);
                  check($sformatf("post_flush_done dut%0d", d), {31'd0, done_s[d]}, 32'd0);
               end else begin
                  rst_s[d] = 1'b1;
                  #1;
                  check($sformatf("rst_done dut%0d", d), {31'd0, done_s[d]}, 32'd0);
                  check($sformatf("rst_stall dut%0d", d), {31'd0, stall_s[d]}, 32'd0);
                  check($sformatf("rst_result dut%0d", d), res_s[d], 32'd0);
                  @(negedge clk);
                  rst_s[d] = 1'b0;
               end
               fin = 1'b1;
            end else if (n > 200) begin
               n_checks++;
               n_fails++;
               $display("FAIL timeout dut%0d: stall still high after %0d cycles, expected %0d",
                        d, n, exp_n);
               fin = 1'b1;
            end else begin
               @(negedge clk);
               rs1_s[d] = $urandom();
               rs2_s[d] = $urandom();
               op_s[d]  = 3'($urandom_range(0, 7));
            end
         end
      end
      start_s[d] = 1'b0;
      if (kill_kind == 0 && n <= 200)
         check($sformatf("stall_cycles dut%0d op%0d", d, op), n, exp_n);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d]   = 1'b1;
         start_s[d] = 1'b0;
         op_s[d]    = 3'd0;
         rs1_s[d]   = 32'h0;
         rs2_s[d]   = 32'h0;
         rd_s[d]    = 5'd0;
         flush_s[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_done dut%0d", d), {31'd0, done_s[d]}, 32'd0);
         check($sformatf("reset_stall dut%0d", d), {31'd0, stall_s[d]}, 32'd0);
         check($sformatf("reset_result dut%0d", d), res_s[d], 32'd0);
         check($sformatf("reset_rd dut%0d", d), {27'd0, rdo_s[d]}, 32'd0);
         rst_s[d] = 1'b0;
      end

      for (int d = 0; d < 2; d++) begin
         run_op(d, OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  0, 0);
         run_op(d, OP_MULH,   32'h80000000, 32'h80000000, 5'd2,  0, 0);
         run_op(d, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  0, 0);
         run_op(d, OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  0, 0);
         run_op(d, OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  0, 0);
         run_op(d, OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  0, 0);
         run_op(d, OP_DIVU,   32'd100,      32'd7,        5'd7,  0, 0);
         run_op(d, OP_REMU,   32'd100,      32'd7,        5'd8,  0, 0);
         run_op(d, OP_DIV,    32'd5,        32'd0,        5'd9,  0, 0);
         run_op(d, OP_REM,    32'd5,        32'd0,        5'd10, 0, 0);
         run_op(d, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 0, 0);
         run_op(d, OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 0, 0);
         run_op(d, OP_MUL,    32'd12345,    32'd678,      5'd13, 1, (d == 0) ? 10 : 5);
         run_op(d, OP_MUL,    32'd3,        32'd4,        5'd14, 0, 0);
         run_op(d, OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd15, 2, 5);
         run_op(d, OP_DIVU,   32'd100,      32'd7,        5'd0,  0, 0);
         repeat (30)
            run_op(d, 3'($urandom_range(0, 7)), pick(), pick(),
                   5'($urandom_range(0, 31)), 0, 0);
      end

      repeat (5) @(negedge clk);
      check("pending_dut0", q0.size(), 32'd0);
      check("pending_dut1", q1.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
